// File: rtl/circuito_projeto_uc_if.sv
// Control/status bundle between the water-level control unit and its datapath.
// The control unit takes the master side; the datapath (or a bench) takes the slave side.
interface circuito_projeto_uc_if;
  logic       ligar;
  logic       fim_medida;
  logic       fim_classificacao;
  logic       descartar_medida;
  logic [2:0] medida_classificacao;
  logic       fim_1s;
  logic       fim_2s;
  logic       fim_carater;
  logic       fim_mensagem;

  logic       zera;
  logic       conta_1s;
  logic       conta_2s;
  logic       mensurar;
  logic       analisa_medida;
  logic       envia;
  logic       muda;
  logic       liga_buzzer_baixa;
  logic       liga_buzzer_alta;
  logic       desliga_buzzers;
  logic       abre_valvula_auto;
  logic       fecha_valvula_auto;
  logic       zera_vlv;
  logic [3:0] db_estado;

  modport master (
    input  ligar, fim_medida, fim_classificacao, descartar_medida, medida_classificacao,
           fim_1s, fim_2s, fim_carater, fim_mensagem,
    output zera, conta_1s, conta_2s, mensurar, analisa_medida, envia, muda,
           liga_buzzer_baixa, liga_buzzer_alta, desliga_buzzers,
           abre_valvula_auto, fecha_valvula_auto, zera_vlv, db_estado
  );

  modport slave (
    output ligar, fim_medida, fim_classificacao, descartar_medida, medida_classificacao,
           fim_1s, fim_2s, fim_carater, fim_mensagem,
    input  zera, conta_1s, conta_2s, mensurar, analisa_medida, envia, muda,
           liga_buzzer_baixa, liga_buzzer_alta, desliga_buzzers,
           abre_valvula_auto, fecha_valvula_auto, zera_vlv, db_estado
  );
endinterface

// File: rtl/circuito_projeto_uc.sv
// Control unit for the water-level monitor: periodic measure / classify / act / transmit
// cycle with a discard counter that escalates to an error state.
module circuito_projeto_uc #(
  parameter int MAX_DESCARTES = 3,
  parameter int W_DESC        = 2
) (
  input  logic             clock,
  input  logic             reset,
  circuito_projeto_uc_if.master uc
);

  typedef enum logic [3:0] {
    inicial         = 4'h0,
    preparacao      = 4'h1,
    espera_1s       = 4'h2,
    mede            = 4'h3,
    aguarda_medida  = 4'h4,
    analisa         = 4'h5,
    aguarda_classif = 4'h6,
    atua            = 4'h7,
    transmite       = 4'h8,
    aguarda_tx      = 4'h9,
    proximo         = 4'hA,
    fim_ciclo       = 4'hB,
    descarte        = 4'hD,
    erro            = 4'hE
  } estado_t;

  localparam logic [W_DESC-1:0] LIMITE_DESC = W_DESC'(MAX_DESCARTES - 1);

  estado_t           estado, proximo_estado;
  logic [W_DESC-1:0] cont_desc;
  logic [2:0]        codigo_reg;
  logic              erro_entrada;
  logic              codigo_valido;
  logic              classif_aceita;

  always_comb begin
    case (uc.medida_classificacao)
      3'b000, 3'b001, 3'b010, 3'b100: codigo_valido = 1'b1;
      default:                        codigo_valido = 1'b0;
    endcase
  end

  assign classif_aceita = uc.fim_classificacao && !uc.descartar_medida && codigo_valido;

  // erro_entrada marks the first cycle in erro so its alarm pulses fire exactly once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= inicial;
      cont_desc    <= '0;
      codigo_reg   <= '0;
      erro_entrada <= 1'b0;
    end else begin
      estado       <= proximo_estado;
      erro_entrada <= (proximo_estado == erro) && (estado != erro);
      if (estado == inicial || (estado == aguarda_classif && classif_aceita))
        cont_desc <= '0;
      else if (estado == descarte)
        cont_desc <= cont_desc + 1'b1;
      if (estado == aguarda_classif && uc.fim_classificacao)
        codigo_reg <= uc.medida_classificacao;
    end
  end

  always_comb begin
    proximo_estado        = estado;
    uc.zera               = 1'b0;
    uc.conta_1s           = 1'b0;
    uc.conta_2s           = 1'b0;
    uc.mensurar           = 1'b0;
    uc.analisa_medida     = 1'b0;
    uc.envia              = 1'b0;
    uc.muda               = 1'b0;
    uc.liga_buzzer_baixa  = 1'b0;
    uc.liga_buzzer_alta   = 1'b0;
    uc.desliga_buzzers    = 1'b0;
    uc.abre_valvula_auto  = 1'b0;
    uc.fecha_valvula_auto = 1'b0;
    uc.zera_vlv           = 1'b0;

    case (estado)
      inicial: begin
        uc.zera     = 1'b1;
        uc.zera_vlv = 1'b1;
        if (uc.ligar) proximo_estado = preparacao;
      end
      preparacao: begin
        uc.zera        = 1'b1;
        proximo_estado = espera_1s;
      end
      espera_1s: begin
        uc.conta_1s = 1'b1;
        if (uc.fim_1s) proximo_estado = mede;
      end
      mede: begin
        uc.mensurar    = 1'b1;
        uc.zera        = 1'b1;
        proximo_estado = aguarda_medida;
      end
      aguarda_medida: begin
        uc.conta_2s = 1'b1;
        if (uc.fim_medida)  proximo_estado = analisa;
        else if (uc.fim_2s) proximo_estado = descarte;
      end
      analisa: begin
        uc.analisa_medida = 1'b1;
        proximo_estado    = aguarda_classif;
      end
      aguarda_classif: begin
        if (uc.fim_classificacao)
          proximo_estado = classif_aceita ? atua : descarte;
      end
      descarte: begin
        proximo_estado = (cont_desc >= LIMITE_DESC) ? erro : mede;
      end
      atua: begin
        case (codigo_reg)
          3'b000: uc.desliga_buzzers = 1'b1;
          3'b001: begin
            uc.liga_buzzer_baixa = 1'b1;
            uc.abre_valvula_auto = 1'b1;
          end
          3'b010: begin
            uc.fecha_valvula_auto = 1'b1;
            uc.desliga_buzzers    = 1'b1;
          end
          3'b100: begin
            uc.liga_buzzer_alta   = 1'b1;
            uc.fecha_valvula_auto = 1'b1;
          end
          default: ;
        endcase
        proximo_estado = transmite;
      end
      transmite: begin
        uc.envia       = 1'b1;
        proximo_estado = aguarda_tx;
      end
      aguarda_tx: begin
        if (uc.fim_carater)
          proximo_estado = uc.fim_mensagem ? fim_ciclo : proximo;
      end
      proximo: begin
        uc.muda        = 1'b1;
        proximo_estado = transmite;
      end
      fim_ciclo: begin
        proximo_estado = uc.ligar ? preparacao : inicial;
      end
      erro: begin
        uc.zera = 1'b1;
        if (erro_entrada) begin
          uc.liga_buzzer_alta   = 1'b1;
          uc.fecha_valvula_auto = 1'b1;
        end
        if (!uc.ligar) proximo_estado = inicial;
      end
      default: proximo_estado = inicial;
    endcase
  end

  assign uc.db_estado = estado;

endmodule
